// File: rtl/board_row_writer.sv
//------------------------------------------------------------------------------
// Module   : board_row_writer
// Purpose  : Write-side owner of the playfield row RAM (ROWS words of COLS
//            bits, row 0 = top, bit c = column c). Executes one command at a
//            time: CLEAR_ALL, PLACE (piece-row mask with collision check) and
//            SWEEP (remove full lines, compact the rows above downwards).
// Ports    : Clock, Reset          - clock (posedge), synchronous active-high reset
//            cmd_valid/cmd_ready   - command handshake (ready only in IDLE)
//            cmd_op/cmd_row/cmd_mask - opcode, PLACE target row and mask
//            rdaddress / q         - RAM read port (q valid one cycle later)
//            wraddress/data/wren   - registered RAM write port
//            done                  - one-cycle completion pulse
//            collision             - result of the last PLACE
//            lines_cleared         - full rows removed by the last SWEEP
//            score                 - cumulative lines cleared
// Options  : BOARD_SCORE_EN - when defined, score accumulates (saturating)
//            lines_cleared at the end of each SWEEP; otherwise score is 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module board_row_writer #(
    parameter int ROWS = 40,
    parameter int COLS = 10,
    parameter int AW   = 6
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [AW-1:0]   cmd_row,
    input  logic [COLS-1:0] cmd_mask,
    output logic [AW-1:0]   rdaddress,
    input  logic [COLS-1:0] q,
    output logic [AW-1:0]   wraddress,
    output logic [COLS-1:0] data,
    output logic            wren,
    output logic            done,
    output logic            collision,
    output logic [AW-1:0]   lines_cleared,
    output logic [15:0]     score
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CLR    = 3'd1;
    localparam logic [2:0] c_ST_P_RD   = 3'd2;
    localparam logic [2:0] c_ST_P_CHK  = 3'd3;
    localparam logic [2:0] c_ST_S_RD   = 3'd4;
    localparam logic [2:0] c_ST_S_CHK  = 3'd5;
    localparam logic [2:0] c_ST_S_FILL = 3'd6;
    localparam logic [2:0] c_ST_FIN    = 3'd7;

    localparam logic [1:0] c_OP_CLEAR = 2'b00;
    localparam logic [1:0] c_OP_PLACE = 2'b01;
    localparam logic [1:0] c_OP_SWEEP = 2'b10;

    localparam logic [AW-1:0] c_LAST_ROW = AW'(ROWS - 1);
    localparam logic [AW-1:0] c_ROWS     = AW'(ROWS);

    logic [2:0]      state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [COLS-1:0] mask_q, mask_d;
    logic [AW-1:0]   rp_q, rp_d;           // SWEEP read pointer
    logic [AW-1:0]   wp_q, wp_d;           // write pointer (CLR counts up, SWEEP counts down)
    logic [AW-1:0]   rdaddress_q, rdaddress_d;
    logic [AW-1:0]   wraddress_q, wraddress_d;
    logic [COLS-1:0] data_q, data_d;
    logic            wren_q, wren_d;
    logic            done_q, done_d;
    logic            collision_q, collision_d;
    logic [AW-1:0]   lines_cleared_q, lines_cleared_d;

    logic            w_accept;
    logic            w_row_full;
    logic [AW-1:0]   w_lc_next;

    assign w_accept   = cmd_valid && (state_q == c_ST_IDLE);
    assign w_row_full = (q == {COLS{1'b1}});
    // Line count including the row under inspection in S_CHK; never exceeds ROWS.
    assign w_lc_next  = (w_row_full && (lines_cleared_q != c_ROWS)) ?
                        lines_cleared_q + AW'(1) : lines_cleared_q;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_CLEAR: state_d = c_ST_CLR;
                        c_OP_PLACE: state_d = c_ST_P_RD;
                        c_OP_SWEEP: state_d = c_ST_S_RD;
                        default:    state_d = c_ST_FIN;
                    endcase
                end
            end
            c_ST_CLR:    if (wp_q == c_LAST_ROW) state_d = c_ST_FIN;
            c_ST_P_RD:   state_d = c_ST_P_CHK;
            c_ST_P_CHK:  state_d = c_ST_FIN;
            c_ST_S_RD:   state_d = c_ST_S_CHK;
            c_ST_S_CHK: begin
                if (rp_q == '0) begin
                    // Fill only needed when at least one row disappeared.
                    state_d = (w_lc_next != '0) ? c_ST_S_FILL : c_ST_FIN;
                end else begin
                    state_d = c_ST_S_RD;
                end
            end
            c_ST_S_FILL: if (wp_q == '0) state_d = c_ST_FIN;
            c_ST_FIN:    state_d = c_ST_IDLE;
            default:     state_d = c_ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Output / datapath next-value logic
    //--------------------------------------------------------------------------
    always_comb begin
        row_d           = row_q;
        mask_d          = mask_q;
        rp_d            = rp_q;
        wp_d            = wp_q;
        rdaddress_d     = rdaddress_q;
        wraddress_d     = wraddress_q;
        data_d          = data_q;
        wren_d          = 1'b0;
        done_d          = 1'b0;
        collision_d     = collision_q;
        lines_cleared_d = lines_cleared_q;

        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    row_d  = cmd_row;
                    mask_d = cmd_mask;
                    case (cmd_op)
                        c_OP_CLEAR: wp_d = '0;
                        // Read address is registered so it is stable during P_RD/S_RD.
                        c_OP_PLACE: rdaddress_d = cmd_row;
                        c_OP_SWEEP: begin
                            rp_d            = c_LAST_ROW;
                            wp_d            = c_LAST_ROW;
                            rdaddress_d     = c_LAST_ROW;
                            lines_cleared_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            c_ST_CLR: begin
                wren_d      = 1'b1;
                wraddress_d = wp_q;
                data_d      = '0;
                if (wp_q != c_LAST_ROW) wp_d = wp_q + AW'(1);
            end
            c_ST_P_CHK: begin
                if ((q & mask_q) != '0) begin
                    collision_d = 1'b1;
                end else begin
                    collision_d = 1'b0;
                    wren_d      = 1'b1;
                    wraddress_d = row_q;
                    data_d      = q | mask_q;
                end
            end
            c_ST_S_CHK: begin
                lines_cleared_d = w_lc_next;
                if (!w_row_full) begin
                    // Kept row moves down to the compaction pointer.
                    wren_d      = 1'b1;
                    wraddress_d = wp_q;
                    data_d      = q;
                    if (wp_q != '0) wp_d = wp_q - AW'(1);
                end
                if (rp_q != '0) begin
                    rp_d        = rp_q - AW'(1);
                    rdaddress_d = rp_q - AW'(1);
                end
            end
            c_ST_S_FILL: begin
                wren_d      = 1'b1;
                wraddress_d = wp_q;
                data_d      = '0;
                if (wp_q != '0) wp_d = wp_q - AW'(1);
            end
            c_ST_FIN: done_d = 1'b1;
            default: ;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            row_q           <= '0;
            mask_q          <= '0;
            rp_q            <= '0;
            wp_q            <= '0;
            rdaddress_q     <= '0;
            wraddress_q     <= '0;
            data_q          <= '0;
            wren_q          <= 1'b0;
            done_q          <= 1'b0;
            collision_q     <= 1'b0;
            lines_cleared_q <= '0;
        end else begin
            row_q           <= row_d;
            mask_q          <= mask_d;
            rp_q            <= rp_d;
            wp_q            <= wp_d;
            rdaddress_q     <= rdaddress_d;
            wraddress_q     <= wraddress_d;
            data_q          <= data_d;
            wren_q          <= wren_d;
            done_q          <= done_d;
            collision_q     <= collision_d;
            lines_cleared_q <= lines_cleared_d;
        end
    end

    //--------------------------------------------------------------------------
    // Score accumulator
    //--------------------------------------------------------------------------
`ifdef BOARD_SCORE_EN
    logic            sweep_op_q, sweep_op_d;
    logic [15:0]     score_q, score_d;
    logic [16:0]     w_score_sum;

    assign w_score_sum = {1'b0, score_q} + 17'(lines_cleared_q);

    always_comb begin
        sweep_op_d = sweep_op_q;
        score_d    = score_q;
        if (w_accept) sweep_op_d = (cmd_op == c_OP_SWEEP);
        if ((state_q == c_ST_FIN) && sweep_op_q) begin
            score_d = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sweep_op_q <= 1'b0;
            score_q    <= '0;
        end else begin
            sweep_op_q <= sweep_op_d;
            score_q    <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

    assign cmd_ready     = (state_q == c_ST_IDLE);
    assign rdaddress     = rdaddress_q;
    assign wraddress     = wraddress_q;
    assign data          = data_q;
    assign wren          = wren_q;
    assign done          = done_q;
    assign collision     = collision_q;
    assign lines_cleared = lines_cleared_q;

endmodule

`default_nettype wire

// File: tb/tb_board_row_writer.sv
`default_nettype none

module tb_board_row_writer;

    localparam int ROWS = 40;
    localparam int COLS = 10;
    localparam int AW   = 6;
    localparam logic [COLS-1:0] FULL = {COLS{1'b1}};

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = 2'b00;
    logic [AW-1:0]   cmd_row = '0;
    logic [COLS-1:0] cmd_mask = '0;
    logic [AW-1:0]   rdaddress;
    logic [COLS-1:0] q;
    logic [AW-1:0]   wraddress;
    logic [COLS-1:0] data;
    logic            wren;
    logic            done;
    logic            collision;
    logic [AW-1:0]   lines_cleared;
    logic [15:0]     score;

    board_row_writer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .Clock(Clock), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_mask(cmd_mask),
        .rdaddress(rdaddress), .q(q),
        .wraddress(wraddress), .data(data), .wren(wren),
        .done(done), .collision(collision),
        .lines_cleared(lines_cleared), .score(score)
    );

    always #5 Clock = ~Clock;

    // RAM model plus a log of every write seen at the RAM port.
    logic [COLS-1:0] mem [0:63];
    int              cyc = 0;
    int              wa_q[$];
    logic [COLS-1:0] wd_q[$];
    int              wc_q[$];

    always @(posedge Clock) begin
        cyc = cyc + 1;
        if (wren) begin
            mem[wraddress] <= data;
            wa_q.push_back(int'(wraddress));
            wd_q.push_back(data);
            wc_q.push_back(cyc);
        end
        q <= mem[rdaddress];
    end

    // Reference board and bookkeeping.
    logic [COLS-1:0] model [0:ROWS-1];
    int checks = 0;
    int errors = 0;
    int score_exp = 0;

    function automatic int model_sweep();
        logic [COLS-1:0] kept[$];
        int n;
        for (int r = ROWS - 1; r >= 0; r--)
            if (model[r] != FULL) kept.push_back(model[r]);
        n = ROWS - kept.size();
        for (int r = ROWS - 1; r >= 0; r--) begin
            int idx;
            idx = ROWS - 1 - r;
            model[r] = (idx < kept.size()) ? kept[idx] : '0;
        end
        return n;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input int row, input logic [COLS-1:0] mask,
                            output int lat);
        int n;
        n = 0;
        @(negedge Clock);
        while (!cmd_ready && n < 50) begin
            @(negedge Clock);
            n++;
        end
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        cmd_op = op; cmd_row = AW'(row); cmd_mask = mask; cmd_valid = 1'b1;
        @(posedge Clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_mask = COLS'($urandom);
        lat = 0;
        do begin
            @(posedge Clock);
            #1;
            lat++;
        end while (!done && lat < 500);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cmd_timeout op=%0d: no done after %0d cycles, required done=1", op, lat);
        end
    endtask

    task automatic check_board(input string name);
        int bad;
        bad = -1;
        for (int r = 0; r < ROWS; r++)
            if (mem[r] !== model[r] && bad < 0) bad = r;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s board row %0d: got %h required %h", name, bad, mem[bad], model[bad]);
        end
    endtask

    task automatic check_score(input string name);
        checks++;
        if (score !== 16'(score_exp)) begin
            errors++;
            $display("FAIL %s score: got %0d required %0d", name, score, score_exp);
        end
    endtask

    task automatic do_place(input int row, input logic [COLS-1:0] mask, input string name);
        logic exp_col;
        int lat;
        exp_col = (model[row] & mask) != '0;
        if (!exp_col) model[row] = model[row] | mask;
        send_cmd(2'b01, row, mask, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s place_latency: got %0d required 3", name, lat);
        end
        checks++;
        if (collision !== exp_col) begin
            errors++;
            $display("FAIL %s collision: got %b required %b", name, collision, exp_col);
        end
        checks++;
        if (wa_q.size() != (exp_col ? 0 : 1)) begin
            errors++;
            $display("FAIL %s place_writes: got %0d required %0d", name, wa_q.size(), exp_col ? 0 : 1);
        end
        check_board(name);
    endtask

    task automatic do_sweep(input string name);
        int lc;
        int lat;
        logic [COLS-1:0] old [0:ROWS-1];
        for (int r = 0; r < ROWS; r++) old[r] = model[r];
        lc = model_sweep();
`ifdef BOARD_SCORE_EN
        score_exp = (score_exp + lc > 65535) ? 65535 : score_exp + lc;
`endif
        send_cmd(2'b10, 0, '0, lat);
        checks++;
        if (lines_cleared !== AW'(lc)) begin
            errors++;
            $display("FAIL %s lines_cleared: got %0d required %0d", name, lines_cleared, lc);
        end
        checks++;
        if (wa_q.size() != ROWS) begin
            errors++;
            $display("FAIL %s sweep_writes: got %0d required %0d", name, wa_q.size(), ROWS);
        end
        if (lc == 0) begin
            int bad;
            bad = -1;
            for (int i = 0; i < wa_q.size(); i++)
                if ((wa_q[i] != ROWS - 1 - i || wd_q[i] !== old[ROWS - 1 - i]) && bad < 0) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s rewrite %0d: got addr %0d data %h required addr %0d data %h",
                         name, bad, wa_q[bad], wd_q[bad], ROWS - 1 - bad, old[ROWS - 1 - bad]);
            end
        end
        check_score(name);
        check_board(name);
    endtask

    task automatic do_clear(input string name);
        int lat;
        int bad;
        for (int r = 0; r < ROWS; r++) model[r] = '0;
        send_cmd(2'b00, 0, '0, lat);
        checks++;
        if (wa_q.size() != ROWS) begin
            errors++;
            $display("FAIL %s clear_writes: got %0d required %0d", name, wa_q.size(), ROWS);
        end
        bad = -1;
        for (int i = 0; i < wa_q.size(); i++)
            if ((wa_q[i] != i || wd_q[i] !== '0 || wc_q[i] != wc_q[0] + i) && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s clear_seq %0d: got addr %0d data %h required addr %0d data 0 consecutive",
                     name, bad, wa_q[bad], wd_q[bad], bad);
        end
        checks++;
        if (wc_q.size() == 0 || wc_q[wc_q.size() - 1] != cyc) begin
            errors++;
            $display("FAIL %s clear_done_timing: done at cycle %0d, required the cycle after the last write",
                     name, cyc);
        end
        check_board(name);
    endtask

    task automatic do_reserved(input string name);
        int lat;
        send_cmd(2'b11, int'($urandom_range(0, ROWS - 1)), COLS'($urandom), lat);
        checks++;
        if (lat != 1 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL %s reserved: got latency %0d writes %0d required 1 and 0", name, lat, wa_q.size());
        end
        check_board(name);
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        checks++;
        if (wren !== 1'b0 || done !== 1'b0 || collision !== 1'b0 || lines_cleared !== '0 ||
            score !== '0 || rdaddress !== '0 || wraddress !== '0 || data !== '0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got wren=%b done=%b col=%b lc=%0d score=%0d rd=%0d wr=%0d data=%h ready=%b required all 0, ready=1",
                     wren, done, collision, lines_cleared, score, rdaddress, wraddress, data, cmd_ready);
        end
        score_exp = 0;
    endtask

    task automatic test_place();
        do_place(39, 10'h00F, "place_empty");
        do_place(39, 10'h018, "place_collide");
        do_place(39, 10'h3F0, "place_fill");
        checks++;
        if (mem[39] !== 10'h3FF) begin
            errors++;
            $display("FAIL place_row39: got %h required 3ff", mem[39]);
        end
    endtask

    task automatic test_sweep_directed();
        do_clear("sweep_dir_clear");
        do_place(38, 10'h3FF, "sweep_dir_p38");
        do_place(39, 10'h3FF, "sweep_dir_p39");
        do_place(37, 10'h201, "sweep_dir_p37");
        do_sweep("sweep_dir");
        checks++;
        if (mem[39] !== 10'h201 || lines_cleared !== AW'(2)) begin
            errors++;
            $display("FAIL sweep_dir_result: got row39=%h lc=%0d required 201 and 2", mem[39], lines_cleared);
        end
    endtask

    task automatic test_sweep_nofull();
        do_clear("nofull_clear");
        for (int i = 0; i < 8; i++) begin
            int r;
            logic [COLS-1:0] m;
            r = int'($urandom_range(0, ROWS - 1));
            m = COLS'($urandom) & ~model[r] & 10'h1FF;
            do_place(r, m, "nofull_place");
        end
        do_sweep("nofull_sweep");
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int sel;
            int r;
            sel = int'($urandom_range(0, 9));
            r = int'($urandom_range(ROWS - 8, ROWS - 1));
            if (sel <= 3)      do_place(r, COLS'($urandom), "rand_place");
            else if (sel <= 6) do_place(r, ~model[r] | ((sel == 6) ? COLS'(1) : COLS'(0)), "rand_fill");
            else if (sel <= 8) do_sweep("rand_sweep");
            else               do_reserved("rand_reserved");
        end
    endtask

    task automatic test_full_board();
        do_clear("full_clear");
        for (int r = 0; r < ROWS; r++) do_place(r, FULL, "full_place");
        do_sweep("full_sweep");
    endtask

    task automatic test_busy_ignored();
        int n;
        do_place(ROWS - 1, 10'h001, "busy_setup");
        @(negedge Clock);
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        cmd_op = 2'b10; cmd_valid = 1'b1;
        @(posedge Clock);
        #1;
        // Busy: present a PLACE that would collide-free fill row 0.
        cmd_op = 2'b01; cmd_row = '0; cmd_mask = FULL;
        repeat (6) @(posedge Clock);
        #1;
        cmd_valid = 1'b0;
        void'(model_sweep());
        n = 0;
        while (!done && n < 500) begin
            @(posedge Clock);
            #1;
            n++;
        end
        repeat (10) begin
            @(posedge Clock);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL busy_extra_done: got done=1 required 0");
            end
        end
        checks++;
        if (wa_q.size() != ROWS) begin
            errors++;
            $display("FAIL busy_writes: got %0d required %0d", wa_q.size(), ROWS);
        end
        check_board("busy_board");
    endtask

    task automatic test_reset_mid_fill();
        int n;
        int bad;
        do_clear("rst_clear");
        for (int r = 0; r < ROWS; r++) do_place(r, FULL, "rst_place");
        @(negedge Clock);
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        cmd_op = 2'b10; cmd_valid = 1'b1;
        @(posedge Clock);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!wren && n < 400) begin
            @(posedge Clock);
            #1;
            n++;
        end
        checks++;
        if (!wren) begin
            errors++;
            $display("FAIL rst_fill_start: got no fill write required wren=1");
        end
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (wren !== 1'b0 || cmd_ready !== 1'b1 || lines_cleared !== '0 || score !== '0) begin
            errors++;
            $display("FAIL rst_abort: got wren=%b ready=%b lc=%0d score=%0d required 0,1,0,0",
                     wren, cmd_ready, lines_cleared, score);
        end
        @(negedge Clock);
        Reset = 1'b0;
        score_exp = 0;
        bad = -1;
        for (int i = 0; i < wa_q.size(); i++) begin
            if ((wa_q[i] != ROWS - 1 - i || wd_q[i] !== '0) && bad < 0) bad = i;
            if (wa_q[i] < ROWS) model[wa_q[i]] = '0;
        end
        checks++;
        if (bad >= 0 || wa_q.size() < 4 || wa_q.size() > 6) begin
            errors++;
            $display("FAIL rst_fill_writes: got %0d writes (first bad %0d) required 4..6 zero writes from row 39 down",
                     wa_q.size(), bad);
        end
        do_reserved("rst_reserved");
        check_score("rst_score");
    endtask

    initial begin
        test_reset();
        do_clear("clear_all");
        test_place();
        test_sweep_directed();
        test_sweep_nofull();
        test_random();
        test_full_board();
        test_busy_ignored();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
